vdp_sync_fifo: RTL and testbench

- Parametrised single-clock show-ahead FIFO for VDP register/VRAM/CRAM write buffering, replacing fixed 36-bit x 8 write queues.
- Adds flush, fill level, almost-full and sticky overflow/underflow error flags.
- Adds write-while-full acceptance when a read occurs in the same cycle.
- Sits between the CPU bus interface and the VDP memory arbiter.

---
 rtl/vdp_sync_fifo.sv | 140 ++++++++++++++
 tb/tb_vdp_sync_fifo.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/vdp_sync_fifo.sv
// vdp_sync_fifo
//   Single-clock show-ahead FIFO that buffers VDP register, VRAM and CRAM writes
//   between the CPU bus interface and the VDP memory arbiter.
//
// Parameters
//   WIDTH     : data word width (1..72)
//   DEPTH     : number of entries, power of two (2..64)
//   AF_MARGIN : ALMOST_FULL asserts when LEVEL >= DEPTH-AF_MARGIN
//   AW        : pointer width, derived from DEPTH
//
// Ports
//   CLK, RST_N   : clock (rising edge), asynchronous active-low reset
//   FLUSH        : synchronous clear of contents, pointers and error flags
//   DATA, WRREQ  : write data and write request
//   RDREQ        : pop request
//   Q            : head-of-queue data, valid while EMPTY=0
//   EMPTY, FULL, LAST, ALMOST_FULL, LEVEL : occupancy status
//   OVF, UDF     : sticky error flags (write dropped / read while empty)

// One storage word. There is no reset on the data, only on the control state.
module vdp_fifo_entry #(
  parameter int WIDTH = 36
) (
  input  logic             CLK,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge CLK)
    if (we) q <= d;
endmodule

module vdp_sync_fifo #(
  parameter  int WIDTH     = 36,
  parameter  int DEPTH     = 8,
  parameter  int AF_MARGIN = 2,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             FLUSH,
  input  logic [WIDTH-1:0] DATA,
  input  logic             WRREQ,
  input  logic             RDREQ,
  output logic [WIDTH-1:0] Q,
  output logic             EMPTY,
  output logic             FULL,
  output logic             LAST,
  output logic             ALMOST_FULL,
  output logic [AW:0]      LEVEL,
  output logic             OVF,
  output logic             UDF
);

  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] LVL_ONE  = (AW+1)'(1);
  // An out-of-range margin degenerates to a threshold of zero, i.e. always set.
  localparam logic [AW:0] AF_THR   = (AF_MARGIN >= DEPTH) ? '0
                                                          : (AW+1)'(DEPTH - AF_MARGIN);

  // Per-cycle decoded operation.
  typedef struct packed {
    logic wr_ok;
    logic rd_ok;
    logic ovf_set;
    logic udf_set;
  } op_t;

  logic [AW-1:0]               raddr, waddr;
  logic [AW:0]                 level;
  logic                        ovf, udf;
  logic                        full, empty;
  op_t                         op;
  logic [DEPTH-1:0]            we;
  logic [DEPTH-1:0][WIDTH-1:0] mem;

  // Occupancy flags come straight from the registered count; pointers are
  // never compared, so wrap needs no extra bit.
  assign full  = (level == LVL_FULL);
  assign empty = (level == '0);

  always_comb begin
    op         = '0;
    // A read in the same cycle frees the head slot, so a write at FULL is kept.
    op.wr_ok   = WRREQ && (!full || RDREQ);
    // No bypass: a read of an empty queue is ignored even with a write present.
    op.rd_ok   = RDREQ && !empty;
    op.ovf_set = WRREQ && full && !RDREQ;
    op.udf_set = RDREQ && empty;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      raddr <= '0;
      waddr <= '0;
      level <= '0;
      ovf   <= 1'b0;
      udf   <= 1'b0;
    end else if (FLUSH) begin
      raddr <= '0;
      waddr <= '0;
      level <= '0;
      ovf   <= 1'b0;
      udf   <= 1'b0;
    end else begin
      if (op.wr_ok) waddr <= waddr + AW'(1);
      if (op.rd_ok) raddr <= raddr + AW'(1);
      case ({op.wr_ok, op.rd_ok})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
      if (op.ovf_set) ovf <= 1'b1;
      if (op.udf_set) udf <= 1'b1;
    end
  end

  // Storage array: one entry instance per slot, write strobe decoded from WADDR.
  // A flushed cycle must not land its data.
  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    assign we[i] = op.wr_ok && !FLUSH && (waddr == AW'(i));
    vdp_fifo_entry #(.WIDTH(WIDTH)) u_ent (
      .CLK (CLK),
      .we  (we[i]),
      .d   (DATA),
      .q   (mem[i])
    );
  end

  // Show-ahead: the head word is read combinationally.
  assign Q           = mem[raddr];
  assign EMPTY       = empty;
  assign FULL        = full;
  assign LAST        = (level == LVL_ONE);
  assign ALMOST_FULL = (level >= AF_THR);
  assign LEVEL       = level;
  assign OVF         = ovf;
  assign UDF         = udf;

endmodule

// File: tb/tb_vdp_sync_fifo.sv
module tb_vdp_sync_fifo;
  localparam int WIDTH = 36;
  localparam int DEPTH = 8;
  localparam int AFM   = 2;
  localparam int AW    = $clog2(DEPTH);

  logic             CLK = 1'b0;
  logic             RST_N = 1'b0;
  logic             FLUSH = 1'b0;
  logic [WIDTH-1:0] DATA = '0;
  logic             WRREQ = 1'b0;
  logic             RDREQ = 1'b0;
  logic [WIDTH-1:0] Q;
  logic             EMPTY, FULL, LAST, ALMOST_FULL, OVF, UDF;
  logic [AW:0]      LEVEL;

  int tests = 0;
  int fails = 0;

  vdp_sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_MARGIN(AFM)) dut (
    .CLK(CLK), .RST_N(RST_N), .FLUSH(FLUSH), .DATA(DATA), .WRREQ(WRREQ),
    .RDREQ(RDREQ), .Q(Q), .EMPTY(EMPTY), .FULL(FULL), .LAST(LAST),
    .ALMOST_FULL(ALMOST_FULL), .LEVEL(LEVEL), .OVF(OVF), .UDF(UDF)
  );

  always #5 CLK = ~CLK;

  // Reference model: a plain queue plus sticky flags.
  logic [WIDTH-1:0] mq[$];
  logic             m_ovf = 1'b0;
  logic             m_udf = 1'b0;

  task automatic model_step(input logic fl, input logic wr, input logic rd,
                            input logic [WIDTH-1:0] d);
    int n = mq.size();
    if (fl) begin
      mq.delete(); m_ovf = 1'b0; m_udf = 1'b0;
    end else begin
      if (wr && n == DEPTH && !rd) m_ovf = 1'b1;
      if (rd && n == 0) m_udf = 1'b1;
      if (rd && n != 0) void'(mq.pop_front());
      if (wr && (n < DEPTH || rd)) mq.push_back(d);
    end
  endtask

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Compare every output against an expected occupancy, flag state and head.
  task automatic chk_all(input string tag, input int lvl, input logic ovf,
                         input logic udf, input logic qv, input logic [WIDTH-1:0] q);
    chk({tag, ".level"}, 72'(LEVEL), 72'(lvl));
    chk({tag, ".empty"}, 72'(EMPTY), 72'(lvl == 0));
    chk({tag, ".full"},  72'(FULL),  72'(lvl == DEPTH));
    chk({tag, ".last"},  72'(LAST),  72'(lvl == 1));
    chk({tag, ".afull"}, 72'(ALMOST_FULL), 72'(lvl >= DEPTH - AFM));
    chk({tag, ".ovf"},   72'(OVF), 72'(ovf));
    chk({tag, ".udf"},   72'(UDF), 72'(udf));
    if (qv) chk({tag, ".q"}, 72'(Q), 72'(q));
  endtask

  task automatic chk_model(input string tag);
    chk_all(tag, mq.size(), m_ovf, m_udf, mq.size() != 0,
            (mq.size() != 0) ? mq[0] : '0);
  endtask

  // Drive at the falling edge, let one rising edge pass, sample 1 time unit later.
  task automatic step(input logic fl, input logic wr, input logic rd,
                      input logic [WIDTH-1:0] d);
    @(negedge CLK);
    FLUSH = fl; WRREQ = wr; RDREQ = rd; DATA = d;
    @(posedge CLK);
    #1;
    model_step(fl, wr, rd, d);
  endtask

  typedef struct {
    logic             fl, wr, rd;
    logic [WIDTH-1:0] d;
    int               lvl;
    logic             ovf, udf, qv;
    logic [WIDTH-1:0] q;
  } vec_t;
  vec_t vt[$];

  function automatic void add(input logic fl, input logic wr, input logic rd,
                              input logic [WIDTH-1:0] d, input int lvl,
                              input logic ovf, input logic udf, input logic qv,
                              input logic [WIDTH-1:0] q);
    vec_t v;
    v.fl = fl; v.wr = wr; v.rd = rd; v.d = d; v.lvl = lvl;
    v.ovf = ovf; v.udf = udf; v.qv = qv; v.q = q;
    vt.push_back(v);
  endfunction

  initial begin
    logic [WIDTH-1:0] r;
    int               lim;

    // Fill 1..8, head stays 1.
    for (int i = 1; i <= 8; i++) add(0, 1, 0, 36'(i), i, 0, 0, 1, 36'h1);
    // Write alone while full: dropped, OVF set.
    add(0, 1, 0, 36'hAA, 8, 1, 0, 1, 36'h1);
    // Write+read while full: both taken, head advances.
    add(0, 1, 1, 36'hBB, 8, 1, 0, 1, 36'h2);
    // Drain: 3..8, then 0xBB with LAST, then empty.
    for (int k = 1; k <= 6; k++) add(0, 0, 1, '0, 8 - k, 1, 0, 1, 36'(2 + k));
    add(0, 0, 1, '0, 1, 1, 0, 1, 36'hBB);
    add(0, 0, 1, '0, 0, 1, 0, 0, '0);
    // Read on empty, then write+read on empty (no bypass).
    add(0, 0, 1, '0, 0, 1, 1, 0, '0);
    add(0, 1, 1, 36'h55, 1, 1, 1, 1, 36'h55);
    add(1, 0, 0, '0, 0, 0, 0, 0, '0);
    add(0, 1, 0, 36'h11, 1, 0, 0, 1, 36'h11);
    // Flush priority at LEVEL=5 with OVF set.
    for (int i = 1; i <= 7; i++) add(0, 1, 0, 36'(32 + i), 1 + i, 0, 0, 1, 36'h11);
    add(0, 1, 0, 36'hAA, 8, 1, 0, 1, 36'h11);
    for (int k = 1; k <= 3; k++) add(0, 0, 1, '0, 8 - k, 1, 0, 1, 36'(32 + k));
    add(1, 1, 0, 36'h99, 0, 0, 0, 0, '0);
    add(0, 1, 0, 36'h11, 1, 0, 0, 1, 36'h11);

    // Reset state.
    #12;
    chk_all("reset", 0, 0, 0, 0, '0);
    @(negedge CLK);
    RST_N = 1'b1;

    foreach (vt[i]) begin
      step(vt[i].fl, vt[i].wr, vt[i].rd, vt[i].d);
      chk_all($sformatf("vec%0d", i), vt[i].lvl, vt[i].ovf, vt[i].udf, vt[i].qv, vt[i].q);
    end

    // Wrap-around: preload to 3, then oscillate 3..5 for 20 write/read pairs.
    step(0, 1, 0, 36'h100); chk_model("wrap.pre");
    step(0, 1, 0, 36'h101); chk_model("wrap.pre");
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 0, 36'(36'h200 + 2 * i));     chk_model("wrap.w");
      step(0, 1, 0, 36'(36'h201 + 2 * i));     chk_model("wrap.w");
      step(0, 0, 1, '0);                       chk_model("wrap.r");
      step(0, 0, 1, '0);                       chk_model("wrap.r");
    end
    chk("wrap.noerr", 72'({OVF, UDF}), 72'(0));

    // Async reset mid-burst at LEVEL=4, between edges, requests held meanwhile.
    step(0, 1, 0, 36'h300); chk_model("ar.fill");
    #2;
    RST_N = 1'b0;
    #1;
    mq.delete(); m_ovf = 1'b0; m_udf = 1'b0;
    chk_all("ar.now", 0, 0, 0, 0, '0);
    @(posedge CLK);
    #1;
    chk_all("ar.held", 0, 0, 0, 0, '0);
    @(negedge CLK);
    RST_N = 1'b1; WRREQ = 1'b0;
    step(0, 1, 0, 36'h777);
    chk_all("ar.first", 1, 0, 0, 1, 36'h777);

    // Randomized traffic against the queue model.
    for (int i = 0; i < 400; i++) begin
      r = {4'($urandom), $urandom};
      lim = (i < 200) ? 70 : 35;  // bias toward filling, then toward draining
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 99) < lim),
           ($urandom_range(0, 99) < 100 - lim + 10), r);
      chk_model("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global guard against a hung run.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
